perf_trace_unit: RTL and testbench

//  In-DUT producer of the commit/perf stream that the trace bench consumes. Instantiated in proc

---
 rtl/perf_trace_pkg.sv | 50 +++++
 rtl/perf_trace_if.sv | 18 +
 rtl/trace_fifo2w.sv | 66 ++++++
 rtl/perf_trace_unit.sv | 159 +++++++++++++++
 tb/tb_perf_trace_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/perf_trace_pkg.sv
// Shared definitions for the perf/trace unit.
// Contents: record kind codes, the 34-bit trace record layout, counter select
// codes, halt-sequencing states and a small record constructor.
package perf_trace_pkg;

  localparam int REC_W   = 34;
  localparam int NUM_CNT = 7;

  typedef enum logic [1:0] {
    REC_REG   = 2'd0,
    REC_LOAD  = 2'd1,
    REC_STORE = 2'd2,
    REC_HALT  = 2'd3
  } rec_kind_e;

  // {kind, tag, value}: 2 + 16 + 16 = 34 bits
  typedef struct packed {
    rec_kind_e   kind;
    logic [15:0] tag;
    logic [15:0] value;
  } trace_rec_t;

  localparam logic [2:0] CNT_CYCLE  = 3'd0;
  localparam logic [2:0] CNT_INST   = 3'd1;
  localparam logic [2:0] CNT_IC_REQ = 3'd2;
  localparam logic [2:0] CNT_IC_HIT = 3'd3;
  localparam logic [2:0] CNT_DC_REQ = 3'd4;
  localparam logic [2:0] CNT_DC_HIT = 3'd5;
  localparam logic [2:0] CNT_DROP   = 3'd6;
  localparam logic [2:0] CNT_ZERO   = 3'd7;

  // RUN: events accepted; PEND: halt retired, HALT record goes out this cycle;
  // HALTED: events ignored until reset.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PEND   = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

  function automatic trace_rec_t make_rec(input rec_kind_e kind,
                                          input logic [15:0] tag,
                                          input logic [15:0] value);
    trace_rec_t r;
    r.kind  = kind;
    r.tag   = tag;
    r.value = value;
    return r;
  endfunction

endpackage

// File: rtl/perf_trace_if.sv
// Trace record stream between the producer (perf_trace_unit) and its consumer.
// Handshake: a record transfers on every clock edge where rec_valid and
// rec_ready are both high; while rec_valid is high and rec_ready is low the
// producer holds rec_kind/rec_tag/rec_value stable; rec_valid never depends on
// rec_ready.
// Signals: rec_valid, rec_ready, rec_kind[1:0], rec_tag[15:0], rec_value[15:0].
interface perf_trace_if;
  logic        rec_valid;
  logic        rec_ready;
  logic [1:0]  rec_kind;
  logic [15:0] rec_tag;
  logic [15:0] rec_value;

  modport master (output rec_valid, output rec_kind, output rec_tag,
                  output rec_value, input rec_ready);
  modport slave  (input rec_valid, input rec_kind, input rec_tag,
                  input rec_value, output rec_ready);
endinterface

// File: rtl/trace_fifo2w.sv
// Circular FIFO with two write lanes and one read port.
// Ports: clk, rst (sync, active-high); wr_req = records offered this cycle
// (0..2, lane 0 is earlier in order); wr_acc = records actually stored;
// rd_en pops the head when rd_valid; rd_data is the head entry.
module trace_fifo2w #(
  parameter int DEPTH = 8,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   wr_req,
  input  logic [W-1:0] wr_data0,
  input  logic [W-1:0] wr_data1,
  output logic [1:0]   wr_acc,
  input  logic         rd_en,
  output logic         rd_valid,
  output logic [W-1:0] rd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_slots;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          pop;

  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign pop      = rd_en & rd_valid;

  always_comb begin
    // A same-cycle pop frees its slot for this cycle's writes.
    free_slots = CW'(DEPTH) - count_q + CW'(pop);
    if (free_slots >= CW'(wr_req)) wr_acc = wr_req;
    else                           wr_acc = free_slots[1:0];

    mem_d = mem_q;
    if (wr_acc != 2'd0) mem_d[wr_ptr_q] = wr_data0;
    if (wr_acc == 2'd2) mem_d[wr_ptr_q + AW'(1)] = wr_data1;

    wr_ptr_d = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(wr_acc) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries below count_q are ever visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/perf_trace_unit.sv
// Commit/perf trace producer beside the MEM/WB boundary.
// Turns retire events into ordered REG/LOAD/STORE/HALT records on rec_if,
// never stalls the pipeline (records that do not fit are dropped and counted),
// and keeps seven perf counters readable through cnt_sel/cnt_data.
// Ports: clk, rst (sync, active-high); retire events reg_write/write_reg/
// write_data, mem_read/mem_write/mem_addr/mem_wdata/mem_rdata, halt, cache
// strobes; rec_if (record stream, master side); cnt_sel -> cnt_data (1-cycle
// latency); sticky halted/overflow; dbg_state exposes the halt sequencer.
module perf_trace_unit
  import perf_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [2:0]        write_reg,
  input  logic [15:0]       write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              halt,
  input  logic              icache_req,
  input  logic              icache_hit,
  input  logic              dcache_req,
  input  logic              dcache_hit,
  perf_trace_if.master      rec_if,
  input  logic [2:0]        cnt_sel,
  output logic [CNT_W-1:0]  cnt_data,
  output logic              halted,
  output logic              overflow,
  output logic [1:0]        dbg_state
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  halt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic [CNT_W-1:0] cnt_d [NUM_CNT];
  logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
  logic             overflow_q, overflow_d;

  logic             active;
  trace_rec_t       rec_reg, rec_mem, push0, push1, head;
  logic [1:0]       push_n, acc_n, drop_n;
  logic             fifo_valid;
  logic [REC_W-1:0] fifo_head;

  assign active = (state_q == ST_RUN);

  // Record builder: REG first, then the memory record; store wins on the
  // illegal read+write combination.
  always_comb begin
    rec_reg = make_rec(REC_REG, {13'b0, write_reg}, write_data);
    rec_mem = mem_write ? make_rec(REC_STORE, mem_addr, mem_wdata)
                        : make_rec(REC_LOAD, mem_addr, mem_rdata);
    push_n  = 2'd0;
    push0   = '0;
    push1   = '0;
    if (state_q == ST_PEND) begin
      push_n = 2'd1;
      push0  = make_rec(REC_HALT, 16'h0000, 16'h0000);
    end else if (active) begin
      if (reg_write) begin
        push0  = rec_reg;
        push1  = rec_mem;
        push_n = (mem_read | mem_write) ? 2'd2 : 2'd1;
      end else if (mem_read | mem_write) begin
        push0  = rec_mem;
        push_n = 2'd1;
      end
    end
  end

  trace_fifo2w #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (push_n),
    .wr_data0 (push0),
    .wr_data1 (push1),
    .wr_acc   (acc_n),
    .rd_en    (rec_if.rec_ready),
    .rd_valid (fifo_valid),
    .rd_data  (fifo_head)
  );

  assign drop_n = push_n - acc_n;

  // Head fields read as zero whenever nothing is queued.
  assign head             = fifo_valid ? trace_rec_t'(fifo_head) : '0;
  assign rec_if.rec_valid = fifo_valid;
  assign rec_if.rec_kind  = head.kind;
  assign rec_if.rec_tag   = head.tag;
  assign rec_if.rec_value = head.value;

  // Halt sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt) state_d = ST_PEND;
      ST_PEND:   state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Counters; cnt_data samples the values from before this cycle's update.
  always_comb begin
    cnt_d = cnt_q;
    if (active) begin
      cnt_d[CNT_CYCLE] = cnt_q[CNT_CYCLE] + ONE;
      if (halt | reg_write | mem_write) cnt_d[CNT_INST]   = cnt_q[CNT_INST] + ONE;
      if (icache_req)                   cnt_d[CNT_IC_REQ] = cnt_q[CNT_IC_REQ] + ONE;
      if (icache_hit)                   cnt_d[CNT_IC_HIT] = cnt_q[CNT_IC_HIT] + ONE;
      if (dcache_req)                   cnt_d[CNT_DC_REQ] = cnt_q[CNT_DC_REQ] + ONE;
      if (dcache_hit)                   cnt_d[CNT_DC_HIT] = cnt_q[CNT_DC_HIT] + ONE;
    end
    // Drops are counted regardless of halt state (the HALT record can drop).
    cnt_d[CNT_DROP] = cnt_q[CNT_DROP] + CNT_W'(drop_n);

    overflow_d = overflow_q | (drop_n != 2'd0);

    case (cnt_sel)
      CNT_CYCLE:  cnt_data_d = cnt_q[CNT_CYCLE];
      CNT_INST:   cnt_data_d = cnt_q[CNT_INST];
      CNT_IC_REQ: cnt_data_d = cnt_q[CNT_IC_REQ];
      CNT_IC_HIT: cnt_data_d = cnt_q[CNT_IC_HIT];
      CNT_DC_REQ: cnt_data_d = cnt_q[CNT_DC_REQ];
      CNT_DC_HIT: cnt_data_d = cnt_q[CNT_DC_HIT];
      CNT_DROP:   cnt_data_d = cnt_q[CNT_DROP];
      default:    cnt_data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_data_q <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_data_q <= cnt_data_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_data  = cnt_data_q;
  assign halted    = (state_q == ST_HALTED);
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

  illegal_mem_rw: assert property (@(posedge clk) disable iff (rst)
    !(active && mem_read && mem_write));

endmodule

// File: tb/tb_perf_trace_unit.sv
// Bench for perf_trace_unit: directed scenarios with literal expectations,
// then randomized traffic, all tracked by a queue-based reference model.
module tb_perf_trace_unit;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        reg_write, mem_read, mem_write, halt;
  logic [2:0]  write_reg, cnt_sel;
  logic [15:0] write_data, mem_addr, mem_wdata, mem_rdata;
  logic        icache_req, icache_hit, dcache_req, dcache_hit;
  logic [CNT_W-1:0] cnt_data;
  logic        halted, overflow;
  logic [1:0]  dbg_state;

  perf_trace_if rec_if();

  perf_trace_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .rec_if(rec_if), .cnt_sel(cnt_sel), .cnt_data(cnt_data),
    .halted(halted), .overflow(overflow), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [33:0]      exp_q[$];   // records expected in the FIFO, head first
  logic [CNT_W-1:0] m_cnt [7];  // cycle, inst, icr, ich, dcr, dch, dropped
  logic [CNT_W-1:0] m_cnt_data;
  logic             m_halted, m_pend, m_ovf;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_step();
    logic [33:0] recs[$];
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 7; i++) m_cnt[i] = '0;
      m_cnt_data = '0;
      m_halted = 1'b0;
      m_pend   = 1'b0;
      m_ovf    = 1'b0;
      return;
    end
    m_cnt_data = (cnt_sel == 3'd7) ? '0 : m_cnt[cnt_sel];
    if (m_pend) begin
      recs.push_back({2'd3, 32'h0});
      m_pend   = 1'b0;
      m_halted = 1'b1;
    end else if (!m_halted) begin
      m_cnt[0] = m_cnt[0] + 1;
      if (halt || reg_write || mem_write) m_cnt[1] = m_cnt[1] + 1;
      if (icache_req) m_cnt[2] = m_cnt[2] + 1;
      if (icache_hit) m_cnt[3] = m_cnt[3] + 1;
      if (dcache_req) m_cnt[4] = m_cnt[4] + 1;
      if (dcache_hit) m_cnt[5] = m_cnt[5] + 1;
      if (reg_write) recs.push_back({2'd0, 13'd0, write_reg, write_data});
      if (mem_write)     recs.push_back({2'd2, mem_addr, mem_wdata});
      else if (mem_read) recs.push_back({2'd1, mem_addr, mem_rdata});
      if (halt) m_pend = 1'b1;
    end
    if (rec_if.rec_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    foreach (recs[i]) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(recs[i]);
      else begin
        m_cnt[6] = m_cnt[6] + 1;
        m_ovf = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard compare (every cycle) ----------------
  logic [33:0] cmp_head;
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_head = (exp_q.size() > 0) ? exp_q[0] : 34'h0;
      check("rec_valid", rec_if.rec_valid, exp_q.size() > 0);
      check("rec_kind",  rec_if.rec_kind,  cmp_head[33:32]);
      check("rec_tag",   rec_if.rec_tag,   cmp_head[31:16]);
      check("rec_value", rec_if.rec_value, cmp_head[15:0]);
      check("cnt_data",  cnt_data, m_cnt_data);
      check("halted",    halted,   m_halted);
      check("overflow",  overflow, m_ovf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_ev();
    reg_write = 0; write_reg = 0; write_data = 0;
    mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
    halt = 0; icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_ev();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_head(input string name, input logic [1:0] k,
                            input logic [15:0] t, input logic [15:0] v);
    check({name, "_valid"}, rec_if.rec_valid, 1'b1);
    check({name, "_kind"},  rec_if.rec_kind, k);
    check({name, "_tag"},   rec_if.rec_tag, t);
    check({name, "_value"}, rec_if.rec_value, v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; clear_ev(); rec_if.rec_ready = 1'b0; cnt_sel = 3'd0;
    tick(); tick();
    chk_en = 1'b1;
    check("reset_valid", rec_if.rec_valid, 1'b0);
    check("reset_tag", rec_if.rec_tag, 16'h0);
    check("reset_cnt", cnt_data, 32'h0);
    check("reset_halted", halted, 1'b0);
    check("reset_ovf", overflow, 1'b0);
    rst = 1'b0;

    // 1: single REG record
    do_reset();
    rec_if.rec_ready = 1'b1;
    reg_write = 1; write_reg = 3'd3; write_data = 16'h1234;
    tick(); clear_ev();
    check_head("t1_reg", 2'd0, 16'h0003, 16'h1234);
    cnt_sel = 3'd1;
    tick();
    check("t1_inst", cnt_data, 32'd1);
    check("t1_empty", rec_if.rec_valid, 1'b0);

    // 2: REG then LOAD from the same cycle
    do_reset();
    rec_if.rec_ready = 1'b0;
    reg_write = 1; write_reg = 3'd1; write_data = 16'hAAAA;
    mem_read = 1; mem_addr = 16'h0040; mem_rdata = 16'h5555;
    tick(); clear_ev();
    check_head("t2_reg", 2'd0, 16'h0001, 16'hAAAA);
    rec_if.rec_ready = 1'b1; cnt_sel = 3'd1;
    tick();
    check_head("t2_load", 2'd1, 16'h0040, 16'h5555);
    check("t2_inst", cnt_data, 32'd1);
    tick();

    // 3: overflow with consumer stalled
    do_reset();
    rec_if.rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      reg_write = 1; write_reg = 3'(i); write_data = 16'h1000 + 16'(i);
      mem_write = 1; mem_addr = 16'h2000 + 16'(i); mem_wdata = 16'h3000 + 16'(i);
      tick();
    end
    clear_ev();
    check("t3_ovf", overflow, 1'b1);
    cnt_sel = 3'd6;
    tick();
    check("t3_dropped", cnt_data, 32'd2);
    check_head("t3_first", 2'd0, 16'h0000, 16'h1000);
    rec_if.rec_ready = 1'b1;
    repeat (7) tick();
    check_head("t3_last", 2'd2, 16'h2003, 16'h3003);
    tick();
    check("t3_drained", rec_if.rec_valid, 1'b0);

    // 4: halt with a store, then frozen counters
    do_reset();
    rec_if.rec_ready = 1'b1;
    halt = 1; mem_write = 1; mem_addr = 16'h0100; mem_wdata = 16'hBEEF;
    tick(); clear_ev();
    check_head("t4_store", 2'd2, 16'h0100, 16'hBEEF);
    check("t4_not_halted", halted, 1'b0);
    tick();
    check_head("t4_halt", 2'd3, 16'h0000, 16'h0000);
    check("t4_halted", halted, 1'b1);
    for (int i = 0; i < 6; i++) begin
      halt = i[0]; reg_write = 1; icache_req = 1;
      tick();
    end
    clear_ev();
    cnt_sel = 3'd0; tick(); check("t4_cycle", cnt_data, 32'd1);
    cnt_sel = 3'd1; tick(); check("t4_inst", cnt_data, 32'd1);
    cnt_sel = 3'd2; tick(); check("t4_icr", cnt_data, 32'd0);
    check("t4_empty", rec_if.rec_valid, 1'b0);

    // 5: I-cache counters
    do_reset();
    for (int i = 0; i < 10; i++) begin
      icache_req = 1; icache_hit = (i < 7);
      tick();
    end
    clear_ev();
    cnt_sel = 3'd3; tick(); check("t5_hits", cnt_data, 32'd7);
    cnt_sel = 3'd2; tick(); check("t5_reqs", cnt_data, 32'd10);
    cnt_sel = 3'd7; tick(); check("t5_sel7", cnt_data, 32'd0);

    // 6: reset with queued records and a pending halt
    do_reset();
    rec_if.rec_ready = 1'b0;
    reg_write = 1; write_reg = 3'd5; write_data = 16'h0055; halt = 1;
    tick(); clear_ev();
    check("t6_queued", rec_if.rec_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", rec_if.rec_valid, 1'b0);
    check("t6_rst_halted", halted, 1'b0);
    cnt_sel = 3'd0; tick(); check("t6_cycle", cnt_data, 32'd0);
    check("t6_no_halt_rec", rec_if.rec_valid, 1'b0);
    check("t6_still_run", halted, 1'b0);
    cnt_sel = 3'd1; tick(); check("t6_inst", cnt_data, 32'd0);
    cnt_sel = 3'd6; tick(); check("t6_drop", cnt_data, 32'd0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int op;
      rst = ($urandom_range(0, 149) == 0);
      reg_write  = $urandom_range(0, 1);
      write_reg  = 3'($urandom_range(0, 7));
      write_data = 16'($urandom);
      op = $urandom_range(0, 2);
      mem_read   = (op == 1);
      mem_write  = (op == 2);
      mem_addr   = 16'($urandom);
      mem_wdata  = 16'($urandom);
      mem_rdata  = 16'($urandom);
      halt       = ($urandom_range(0, 59) == 0);
      icache_req = $urandom_range(0, 1);
      icache_hit = $urandom_range(0, 1);
      dcache_req = $urandom_range(0, 1);
      dcache_hit = $urandom_range(0, 1);
      rec_if.rec_ready = ($urandom_range(0, 9) < 5);
      cnt_sel    = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;
    clear_ev();
    rec_if.rec_ready = 1'b1;
    repeat (DEPTH + 2) tick();

    @(posedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
